// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and byte type.
// Used by the receiver, the transmitter and the receive-side FIFO.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_level_to_pulse.sv
// Turns a multi-cycle level into a single-cycle pulse on its rising edge.
// History flop resets to 1 so a level already high at reset release is ignored.
module uart_level_to_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_d;
    logic level_q;

    always_comb begin
        level_d = level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level_d;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO behind the UART receiver, with sticky overflow on dropped bytes.
// Optional almost-full output enabled by defining UART_RX_FIFO_AFULL_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    parameter int AFULL_LEVEL = 12
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [UART_DATA_W-1:0]        in_data,
    input  logic                          in_data_ready,
    output logic [UART_DATA_W-1:0]        out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    input  logic                          clr_overflow
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    output logic                          afull
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;

    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;
    logic          overflow_d;
    logic          overflow_q;

    uart_byte_t    mem_q [DEPTH];

    uart_level_to_pulse u_ready_edge (
        .clk   (clk),
        .rst   (rst),
        .level (in_data_ready),
        .pulse (push)
    );

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        pop        = out_valid & out_ready;
        wr_en      = push & (~full | pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (push & ~wr_en) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef UART_RX_FIFO_AFULL_EN
    assign afull = (count_q >= CW'(AFULL_LEVEL));
`endif

endmodule
